bs_rr_sched: RTL and testbench

- Round-robin scheduler for the single shared parallel bus used by `drvrs` driver FIFOs.
- Picks one pending driver, pops one word from it, decodes the destination ID in the word's top 8 bits, then pushes the word to the target driver. A broadcast ID sends it to every driver except the source.
- Sits between the driver FIFO array and the bus wrapper, and owns all pop/push strobes for bus 0.

---
 rtl/bs_rr_sched.sv | 129 ++++++++++++
 tb/tb_bs_rr_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bs_rr_sched.sv
// Round-robin scheduler for the shared driver bus: pop one word, decode its top byte, push to target(s).
// Optional build macro BS_RR_SCHED_SELF_BCAST_EN: broadcast words also return to the source driver.
module bs_rr_sched #(
  parameter int         bits      = 32,
  parameter int         drvrs     = 5,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [drvrs-1:0]        i_pndng,
  input  logic [drvrs*bits-1:0]   i_d_pop,
  output logic [drvrs-1:0]        o_pop,
  output logic [drvrs-1:0]        o_push,
  output logic [bits-1:0]         o_d_push,
  output logic [3:0]              o_grant_id,
  output logic                    o_busy,
  output logic                    o_err_drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  localparam logic [drvrs-1:0] ONE = drvrs'(1);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [3:0]         r_last;
  logic [3:0]         r_grant;
  logic [3:0]         w_pick;
  logic               w_found;
  logic [4:0]         w_idx;
  logic               w_hit;
  logic [bits-1:0]    r_word;
  logic [bits-1:0]    w_word_in;
  logic [drvrs-1:0]   w_grant_oh;
  logic [drvrs-1:0]   w_bcast_mask;
  logic               w_take;
  logic [7:0]         w_dst;

  // Reset asserts asynchronously but is released only on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      w_idx = 5'(r_last) + 5'(k);
      if (w_idx >= 5'(drvrs)) w_idx = w_idx - 5'(drvrs);
      w_hit = |(i_pndng & (ONE << w_idx));
      if (!w_found && w_hit) begin
        w_found = 1'b1;
        w_pick  = w_idx[3:0];
      end
    end
  end

  assign w_grant_oh = ONE << r_grant;
  assign w_take     = |(i_pndng & w_grant_oh);
  assign w_word_in  = bits'(i_d_pop >> (int'(r_grant) * bits));
  assign w_dst      = r_word[bits-1 -: 8];

`ifdef BS_RR_SCHED_SELF_BCAST_EN
  assign w_bcast_mask = '1;
`else
  assign w_bcast_mask = ~w_grant_oh;
`endif

  always_comb begin
    w_next     = r_state;
    o_pop      = '0;
    o_push     = '0;
    o_err_drop = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) w_next = POP;
      end
      POP: begin
        // A driver that withdrew its request is skipped without touching the pointer.
        if (w_take) begin
          o_pop  = w_grant_oh;
          w_next = PUSH;
        end else begin
          w_next = IDLE;
        end
      end
      PUSH: begin
        if (w_dst == broadcast)       o_push = w_bcast_mask;
        else if (w_dst < 8'(drvrs))   o_push = ONE << w_dst;
        else                          o_err_drop = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_last  <= 4'(drvrs - 1);
      r_grant <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) r_grant <= w_pick;
      if (r_state == POP && w_take) begin
        r_word <= w_word_in;
        r_last <= r_grant;
      end
    end
  end

  // The word register doubles as the bus driver, so the bus holds its last value between pushes.
  assign o_d_push   = r_word;
  assign o_grant_id = r_grant;
  assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_bs_rr_sched.sv
// Randomized self-checking bench for bs_rr_sched with a transaction-level reference model.
// Honors BS_RR_SCHED_SELF_BCAST_EN for the expected broadcast mask.
module tb_bs_rr_sched;

  localparam int BITS = 32;
  localparam int NDRV = 5;

`ifdef BS_RR_SCHED_SELF_BCAST_EN
  localparam logic [4:0] BCAST_EXP = 5'b11111;
`else
  localparam logic [4:0] BCAST_EXP = 5'b11101;
`endif

  logic              clk = 1'b0;
  logic              rstN;
  logic [4:0]        pndng;
  logic [31:0]       dPopArr [NDRV];
  logic [NDRV*BITS-1:0] dPopFlat;
  logic [4:0]        pop;
  logic [4:0]        push;
  logic [31:0]       dPush;
  logic [3:0]        grantId;
  logic              busy;
  logic              errDrop;

  int                checks = 0;
  int                errors = 0;
  int                mLast;
  logic [3:0]        seenGrant;
  logic [4:0]        seenPush;
  int                fairExp [6] = '{0, 1, 2, 3, 4, 0};

  always #5 clk = ~clk;

  always_comb begin
    dPopFlat = '0;
    for (int i = 0; i < NDRV; i++) dPopFlat[i*BITS +: BITS] = dPopArr[i];
  end

  bs_rr_sched #(.bits(BITS), .drvrs(NDRV), .broadcast(8'hFF)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_pndng    (pndng),
    .i_d_pop    (dPopFlat),
    .o_pop      (pop),
    .o_push     (push),
    .o_d_push   (dPush),
    .o_grant_id (grantId),
    .o_busy     (busy),
    .o_err_drop (errDrop)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first pending driver after the last served one, wrapping modulo NDRV.
  function automatic int modelGrant(input logic [4:0] pnd);
    for (int k = 1; k <= NDRV; k++) begin
      if (pnd[(mLast + k) % NDRV]) return (mLast + k) % NDRV;
    end
    return 0;
  endfunction

  function automatic logic [4:0] modelMask(input logic [31:0] word, input int src);
    logic [4:0] m;
    int dst;
    dst = int'(word[31:24]);
    m   = '0;
    if (dst == 255) begin
      m = 5'b11111;
`ifndef BS_RR_SCHED_SELF_BCAST_EN
      m[src] = 1'b0;
`endif
    end else if (dst < NDRV) begin
      m[dst] = 1'b1;
    end
    return m;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Pop"}, 32'(pop), 32'd0);
    checkOutput({tag, "Push"}, 32'(push), 32'd0);
    checkOutput({tag, "ErrDrop"}, 32'(errDrop), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; runs one full grant/pop/push transaction.
  task automatic applyStimulus(input logic [4:0] pnd, input bit withdraw);
    int g;
    logic [4:0] expMask;
    logic [31:0] word;
    g = modelGrant(pnd);
    pndng = pnd;
    @(posedge clk);
    @(negedge clk);
    seenGrant = grantId;
    checkOutput("grantId", 32'(grantId), 32'(g));
    checkOutput("busyInPop", 32'(busy), 32'd1);
    if (withdraw) begin
      pndng[g] = 1'b0;
      #1;
      checkOutput("popWithdrawn", 32'(pop), 32'd0);
      @(negedge clk);
      checkIdle("afterWithdraw");
    end else begin
      word    = dPopArr[g];
      expMask = modelMask(word, g);
      checkOutput("pop", 32'(pop), 32'(5'b00001 << g));
      checkOutput("pushInPop", 32'(push), 32'd0);
      @(negedge clk);
      seenPush = push;
      checkOutput("push", 32'(push), 32'(expMask));
      checkOutput("dPush", dPush, word);
      checkOutput("errDrop", 32'(errDrop), 32'(expMask == 5'b00000));
      checkOutput("popInPush", 32'(pop), 32'd0);
      mLast = g;
      @(negedge clk);
      checkIdle("afterPush");
      checkOutput("dPushHeld", dPush, word);
    end
    pndng = '0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    logic [4:0]  pnd;
    rstN  = 1'b0;
    pndng = '0;
    for (int i = 0; i < NDRV; i++) dPopArr[i] = '0;
    mLast = NDRV - 1;
    repeat (3) @(negedge clk);
    checkIdle("inReset");
    rstN = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkIdle("postReset");
      checkOutput("postResetGrant", 32'(grantId), 32'd0);
      checkOutput("postResetDPush", dPush, 32'd0);
    end

    for (int i = 0; i < NDRV; i++) dPopArr[i] = {8'h00, 24'(i + 16)};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(5'b11111, 1'b0);
      checkOutput("fairSeq", 32'(seenGrant), 32'(fairExp[i]));
    end

    dPopArr[2] = 32'h0300ABCD;
    applyStimulus(5'b00100, 1'b0);
    checkOutput("unicastMask", 32'(seenPush), 32'h08);

    dPopArr[1] = 32'hFF000001;
    applyStimulus(5'b00010, 1'b0);
    checkOutput("bcastMask", 32'(seenPush), 32'(BCAST_EXP));

    dPopArr[4] = 32'h07000000;
    applyStimulus(5'b10000, 1'b0);
    checkOutput("invalidMask", 32'(seenPush), 32'd0);
    dPopArr[0] = 32'h02000055;
    applyStimulus(5'b11111, 1'b0);
    checkOutput("afterInvalidGrant", 32'(seenGrant), 32'd0);

    dPopArr[3] = 32'h01000033;
    applyStimulus(5'b01000, 1'b1);

    dPopArr[2] = 32'h01001234;
    pndng = 5'b00100;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pushBeforeReset", 32'(push), 32'h02);
    rstN = 1'b0;
    #1;
    checkIdle("midOpReset");
    checkOutput("midOpResetDPush", dPush, 32'd0);
    pndng = '0;
    repeat (3) @(negedge clk);
    rstN  = 1'b1;
    mLast = NDRV - 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDRV; i++) dPopArr[i] = {8'h04, 24'(i)};
    applyStimulus(5'b11111, 1'b0);
    checkOutput("afterResetGrant", 32'(seenGrant), 32'd0);

    repeat (80) begin
      for (int i = 0; i < NDRV; i++) begin
        w = $urandom();
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: w[31:24] = 8'($urandom_range(0, NDRV - 1));
          6, 7:             w[31:24] = 8'hFF;
          default:          w[31:24] = 8'($urandom_range(NDRV, 254));
        endcase
        dPopArr[i] = w;
      end
      pnd = 5'($urandom_range(1, 31));
      applyStimulus(pnd, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        checkIdle("randIdle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
